id_stage_pipelined: RTL
=======================

Name: id_stage_pipelined

Overview:
Parametrised successor to the ARM decode stage.
- Decodes one 32-bit ARM instruction per cycle.
- Reads the register file with write-back bypass and applies the condition check against the status register.
- Captures all decoded fields into an internal ID/EXE pipeline register with valid/ready flow control, hazard bubble insertion and branch flush.
- Sits between the IF/ID register and the EXE stage; the separate ID/EXE register module is no longer needed.

Parameters:
DATA_W, 32, width of register values, PC and write-back data
NUM_REGS, 16, register file entries (2..16)
REG_AW, 4, register index width; must equal 4 for ARM encoding

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  synchronous, active-high reset
PC_in  in  DATA_W  PC+4 of the instruction from IF/ID
instruction  in  32  instruction word
in_valid  in  1  instruction and PC_in are valid
in_ready  out  1  stage accepts an instruction this cycle (combinational)
hazard  in  1  hazard unit requests a bubble
flush  in  1  taken branch resolved in EXE; kill the stage content
SR  in  4  status flags {N,Z,C,V}
Result_WB  in  DATA_W  write-back data
writeBackEn  in  1  write-back enable
Dest_wb  in  REG_AW  write-back register index
src1  out  REG_AW  comb: instruction[19:16]
src2  out  REG_AW  comb: instruction[15:12] if decoded store, else instruction[3:0]
Two_src  out  1  comb: ~instruction[25] OR decoded store
out_valid  out  1  registered: EXE outputs hold a valid slot
out_ready  in  1  EXE accepts the current slot
WB_EN, MEM_R_EN, MEM_W_EN, B, S  out  1 each  registered control bits
EXE_CMD  out  4  registered ALU command
Val_Rn, Val_Rm  out  DATA_W  registered operand values
PC_out  out  DATA_W  registered PC
imm  out  1  registered instruction[25]
Shift_operand  out  12  registered instruction[11:0]
Signed_imm_24  out  24  registered instruction[23:0]
Dest  out  REG_AW  registered instruction[15:12]
src1_q, src2_q  out  REG_AW  registered src1/src2, for forwarding

Behaviour:
Reset:
- rst=1 at a clock edge clears every register-file entry and every registered output to 0, including out_valid.
- Reset during a stall or mid-stream discards the held slot.

Register file:
- Write when writeBackEn=1 and Dest_wb<NUM_REGS; indices >=NUM_REGS are ignored on write and read as 0.
- Reads are combinational and write-first: if writeBackEn=1 and Dest_wb==src, the read returns Result_WB in the same cycle.

Condition check (instruction[31:28]):
- Codes 0000..1101 follow standard ARM semantics: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE.
- 1110 = always. 1111 = never.

Decode:
- mode = instruction[27:26], op = instruction[24:21], Sb = instruction[20].
- mode 00, data processing. op -> EXE_CMD:
  MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000, CMP 1010->0100, TST 1000->0110.
  WB_EN=1 except CMP and TST. S=Sb. Undefined op -> all controls 0.
- mode 01, memory. EXE_CMD=0010.
  Sb=1: LDR, MEM_R_EN=1, WB_EN=1.
  Sb=0: STR, MEM_W_EN=1.
  S=0.
- mode 10, branch: B=1, EXE_CMD=0000.
- mode 11: all controls 0.
- Condition fail: controls forced to 0; the slot stays valid and the data fields still load.

Flow control:
- in_ready = (~out_valid | out_ready) & ~hazard & ~flush.
- Next-state priority per edge:
  1. rst
  2. flush: out_valid<=0, controls<=0
  3. out_valid & ~out_ready: hold all outputs
  4. hazard or ~in_valid: bubble, out_valid<=0, controls<=0; data fields don't-care but deterministic
  5. load: out_valid<=1 with all decoded fields.
- Latency: 1 cycle from acceptance to outputs.
- Flush during a stall kills the held slot.
- Write-back in the same cycle as a hold does not update the held Val_Rn/Val_Rm.

Test Plan:
- Reset then ADD R1,R2,R3 (0xE0821003) with R2=5, R3=7, in_valid=1, out_ready=1 -> next cycle out_valid=1, EXE_CMD=0010, WB_EN=1, Val_Rn=5, Val_Rm=7, Dest=1.
- Bypass: writeBackEn=1, Dest_wb=2, Result_WB=0x55 in the same cycle as decode of an instruction reading R2 -> Val_Rn=0x55.
- Condition: ADDEQ with SR=0000 -> out_valid=1, WB_EN=0, EXE_CMD=0. With SR=0100 -> WB_EN=1.
- Stall: out_ready=0 for 3 cycles holding a STR (0xE5821004) -> outputs constant, MEM_W_EN=1, in_ready=0, src2=1, Two_src=1. Release -> next instruction loads one cycle later.
- Hazard=1 with valid input -> in_ready=0, next out_valid=0 with all controls 0. Flush asserted during a stall -> out_valid=0 next cycle.
- rst asserted mid-stream with writes to R0..R15 -> all registers and outputs read 0 afterwards. Write to index 15 with NUM_REGS=8 -> ignored, reads 0.

Source files
------------

// File: rtl/id_stage_pipelined_if.sv
// Bundle between IF/ID, write-back, hazard unit and EXE for the ARM decode stage.
// master drives instructions, write-back and EXE readiness; slave is the decode stage.
interface id_stage_pipelined_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
);
    logic [DATA_W-1:0] PC_in;
    logic [31:0]       instruction;
    logic              in_valid;
    logic              in_ready;
    logic              hazard;
    logic              flush;
    logic [3:0]        SR;
    logic [DATA_W-1:0] Result_WB;
    logic              writeBackEn;
    logic [REG_AW-1:0] Dest_wb;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic              Two_src;
    logic              out_valid;
    logic              out_ready;
    logic              WB_EN;
    logic              MEM_R_EN;
    logic              MEM_W_EN;
    logic              B;
    logic              S;
    logic [3:0]        EXE_CMD;
    logic [DATA_W-1:0] Val_Rn;
    logic [DATA_W-1:0] Val_Rm;
    logic [DATA_W-1:0] PC_out;
    logic              imm;
    logic [11:0]       Shift_operand;
    logic [23:0]       Signed_imm_24;
    logic [REG_AW-1:0] Dest;
    logic [REG_AW-1:0] src1_q;
    logic [REG_AW-1:0] src2_q;

    modport master (
        output PC_in, instruction, in_valid, hazard, flush, SR,
               Result_WB, writeBackEn, Dest_wb, out_ready,
        input  in_ready, src1, src2, Two_src, out_valid, WB_EN, MEM_R_EN,
               MEM_W_EN, B, S, EXE_CMD, Val_Rn, Val_Rm, PC_out, imm,
               Shift_operand, Signed_imm_24, Dest, src1_q, src2_q
    );

    modport slave (
        input  PC_in, instruction, in_valid, hazard, flush, SR,
               Result_WB, writeBackEn, Dest_wb, out_ready,
        output in_ready, src1, src2, Two_src, out_valid, WB_EN, MEM_R_EN,
               MEM_W_EN, B, S, EXE_CMD, Val_Rn, Val_Rm, PC_out, imm,
               Shift_operand, Signed_imm_24, Dest, src1_q, src2_q
    );
endinterface

// File: rtl/id_stage_pipelined.sv
// ARM decode stage: register file with write-back bypass, condition check and
// decode, feeding a built-in ID/EXE register with valid/ready, bubbles and flush.
module id_stage_pipelined #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int REG_AW   = 4
) (
    input logic                clk,
    input logic                rst,
    id_stage_pipelined_if.slave bus
);

    typedef struct packed {
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       b;
        logic       s;
        logic [3:0] exe_cmd;
    } ctrl_t;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [1:0]        mode;
    logic [3:0]        op;
    logic              sb;
    logic              is_store;
    logic              wb_valid;
    logic [DATA_W-1:0] rn_val;
    logic [DATA_W-1:0] rm_val;
    ctrl_t             dec;
    ctrl_t             ctrl;
    ctrl_t             ctrl_q;
    logic              out_valid_q;

    assign mode     = bus.instruction[27:26];
    assign op       = bus.instruction[24:21];
    assign sb       = bus.instruction[20];
    assign is_store = (mode == 2'b01) && !sb;

    assign bus.src1     = bus.instruction[19:16];
    assign bus.src2     = is_store ? bus.instruction[15:12] : bus.instruction[3:0];
    assign bus.Two_src  = ~bus.instruction[25] | is_store;
    assign bus.in_ready = (~out_valid_q | bus.out_ready) & ~bus.hazard & ~bus.flush;

    // Out-of-range write-back targets neither update nor bypass.
    assign wb_valid = bus.writeBackEn && (int'(bus.Dest_wb) < NUM_REGS);

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] sr);
        logic n, z, cf, v;
        {n, z, cf, v} = sr;
        case (c)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = ~z;
            4'b0010: cond_pass = cf;
            4'b0011: cond_pass = ~cf;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = ~n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = ~v;
            4'b1000: cond_pass = cf & ~z;
            4'b1001: cond_pass = ~cf | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = ~z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        rn_val = '0;
        rm_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.src1 == REG_AW'(i)) rn_val = regs[i];
            if (bus.src2 == REG_AW'(i)) rm_val = regs[i];
        end
        if (wb_valid && bus.Dest_wb == bus.src1) rn_val = bus.Result_WB;
        if (wb_valid && bus.Dest_wb == bus.src2) rm_val = bus.Result_WB;
    end

    always_comb begin
        dec = '0;
        case (mode)
            2'b00: begin
                dec.s     = sb;
                dec.wb_en = 1'b1;
                case (op)
                    4'b1101: dec.exe_cmd = 4'b0001;
                    4'b1111: dec.exe_cmd = 4'b1001;
                    4'b0100: dec.exe_cmd = 4'b0010;
                    4'b0101: dec.exe_cmd = 4'b0011;
                    4'b0010: dec.exe_cmd = 4'b0100;
                    4'b0110: dec.exe_cmd = 4'b0101;
                    4'b0000: dec.exe_cmd = 4'b0110;
                    4'b1100: dec.exe_cmd = 4'b0111;
                    4'b0001: dec.exe_cmd = 4'b1000;
                    4'b1010: begin dec.exe_cmd = 4'b0100; dec.wb_en = 1'b0; end
                    4'b1000: begin dec.exe_cmd = 4'b0110; dec.wb_en = 1'b0; end
                    default: dec = '0;
                endcase
            end
            2'b01: begin
                dec.exe_cmd = 4'b0010;
                if (sb) begin
                    dec.mem_r_en = 1'b1;
                    dec.wb_en    = 1'b1;
                end else begin
                    dec.mem_w_en = 1'b1;
                end
            end
            2'b10: dec.b = 1'b1;
            default: dec = '0;
        endcase
        ctrl = cond_pass(bus.instruction[31:28], bus.SR) ? dec : '0;
    end

    always_ff @(posedge clk) begin
        // NOTE: the register file is cleared on reset because software may read a register before ever writing it.
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (wb_valid && bus.Dest_wb == REG_AW'(i)) regs[i] <= bus.Result_WB;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            out_valid_q       <= 1'b0;
            ctrl_q            <= '0;
            bus.Val_Rn        <= '0;
            bus.Val_Rm        <= '0;
            bus.PC_out        <= '0;
            bus.imm           <= 1'b0;
            bus.Shift_operand <= '0;
            bus.Signed_imm_24 <= '0;
            bus.Dest          <= '0;
            bus.src1_q        <= '0;
            bus.src2_q        <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
        end else if (!out_valid_q || bus.out_ready) begin
            // Bubbles keep the old data fields; only valid and controls drop.
            if (bus.hazard || !bus.in_valid) begin
                out_valid_q <= 1'b0;
                ctrl_q      <= '0;
            end else begin
                out_valid_q       <= 1'b1;
                ctrl_q            <= ctrl;
                bus.Val_Rn        <= rn_val;
                bus.Val_Rm        <= rm_val;
                bus.PC_out        <= bus.PC_in;
                bus.imm           <= bus.instruction[25];
                bus.Shift_operand <= bus.instruction[11:0];
                bus.Signed_imm_24 <= bus.instruction[23:0];
                bus.Dest          <= bus.instruction[15:12];
                bus.src1_q        <= bus.src1;
                bus.src2_q        <= bus.src2;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.WB_EN     = ctrl_q.wb_en;
    assign bus.MEM_R_EN  = ctrl_q.mem_r_en;
    assign bus.MEM_W_EN  = ctrl_q.mem_w_en;
    assign bus.B         = ctrl_q.b;
    assign bus.S         = ctrl_q.s;
    assign bus.EXE_CMD   = ctrl_q.exe_cmd;

endmodule
